// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, RGB444 type and colour palette,
// used by the scan driver and the field renderer.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_CNT_W = 11;
  localparam int VGA_BAR_W = 80;

  typedef logic [11:0] rgb444_t;

  localparam rgb444_t COLOR_WHITE   = 12'hFFF;
  localparam rgb444_t COLOR_YELLOW  = 12'hFF0;
  localparam rgb444_t COLOR_CYAN    = 12'h0FF;
  localparam rgb444_t COLOR_GREEN   = 12'h0F0;
  localparam rgb444_t COLOR_MAGENTA = 12'hF0F;
  localparam rgb444_t COLOR_RED     = 12'hF00;
  localparam rgb444_t COLOR_BLUE    = 12'h00F;
  localparam rgb444_t COLOR_BLACK   = 12'h000;

  // Eight 80-pixel colour bars across the visible line; anything past bar 7 is black.
  function automatic rgb444_t bar_color(input logic [VGA_CNT_W-1:0] x);
    logic [VGA_CNT_W-1:0] idx;
    idx = x / VGA_CNT_W'(VGA_BAR_W);
    case (idx)
      11'd0:   bar_color = COLOR_WHITE;
      11'd1:   bar_color = COLOR_YELLOW;
      11'd2:   bar_color = COLOR_CYAN;
      11'd3:   bar_color = COLOR_GREEN;
      11'd4:   bar_color = COLOR_MAGENTA;
      11'd5:   bar_color = COLOR_RED;
      11'd6:   bar_color = COLOR_BLUE;
      default: bar_color = COLOR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Modulo-MAX counter with enable; o_wrap flags the enabled step that returns to 0,
// so instances chain by feeding one o_wrap into the next i_en.
module scan_counter #(
  parameter int W   = 11,
  parameter int MAX = 800
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] r_count;

  assign o_count = r_count;
  assign o_wrap  = i_en && (r_count == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_count <= '0;
    else if (i_en)
      r_count <= o_wrap ? '0 : r_count + W'(1);
  end

endmodule

// File: rtl/vga_scan_driver.sv
// VGA raster generator: scan coordinates out, renderer pixel in, colour and sync
// registered one pixel tick later. Define VGA_TEST_PATTERN_EN for the test_mode colour-bar input.
module vga_scan_driver
  import vga_timing_pkg::*;
#(
  parameter int      CLK_DIV  = 2,
  parameter int      H_ACTIVE = VGA_H_ACTIVE,
  parameter int      H_FP     = VGA_H_FP,
  parameter int      H_SYNC   = VGA_H_SYNC,
  parameter int      H_BP     = VGA_H_BP,
  parameter int      V_ACTIVE = VGA_V_ACTIVE,
  parameter int      V_FP     = VGA_V_FP,
  parameter int      V_SYNC   = VGA_V_SYNC,
  parameter int      V_BP     = VGA_V_BP,
  parameter logic    SYNC_POL = 1'b0,
  parameter rgb444_t FG_COLOR = COLOR_WHITE,
  parameter rgb444_t BG_COLOR = COLOR_BLACK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 px_data,
  output logic [VGA_CNT_W-1:0] x,
  output logic [VGA_CNT_W-1:0] y,
  output logic                 hsync,
  output logic                 vsync,
  output logic [3:0]           red,
  output logic [3:0]           green,
  output logic [3:0]           blue,
  output logic                 active,
  output logic                 frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  input  logic                 test_mode
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [VGA_CNT_W-1:0] H_ACT  = VGA_CNT_W'(H_ACTIVE);
  localparam logic [VGA_CNT_W-1:0] V_ACT  = VGA_CNT_W'(V_ACTIVE);
  localparam logic [VGA_CNT_W-1:0] HS_BEG = VGA_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [VGA_CNT_W-1:0] HS_END = VGA_CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VGA_CNT_W-1:0] VS_BEG = VGA_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [VGA_CNT_W-1:0] VS_END = VGA_CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [3:0]           w_div_cnt_unused;
  logic                 w_tick;
  logic                 w_x_wrap;
  logic                 w_y_wrap;
  logic [VGA_CNT_W-1:0] w_x;
  logic [VGA_CNT_W-1:0] w_y;

  // Stage 1: pixel divider -> x -> y, chained through the wrap strobes.
  scan_counter #(.W(4), .MAX(CLK_DIV)) u_div (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (1'b1),
    .o_count (w_div_cnt_unused),
    .o_wrap  (w_tick)
  );

  scan_counter #(.W(VGA_CNT_W), .MAX(H_TOTAL)) u_x (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (w_tick),
    .o_count (w_x),
    .o_wrap  (w_x_wrap)
  );

  scan_counter #(.W(VGA_CNT_W), .MAX(V_TOTAL)) u_y (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (w_x_wrap),
    .o_count (w_y),
    .o_wrap  (w_y_wrap)
  );

  logic    w_hs_on;
  logic    w_vs_on;
  logic    w_act;
  rgb444_t w_rgb;

  // Decode for the coordinate currently presented; px_data has settled by the tick.
  always_comb begin
    w_hs_on = (w_x >= HS_BEG) && (w_x <= HS_END);
    w_vs_on = (w_y >= VS_BEG) && (w_y <= VS_END);
    w_act   = (w_x < H_ACT) && (w_y < V_ACT);
    w_rgb   = px_data ? FG_COLOR : BG_COLOR;
`ifdef VGA_TEST_PATTERN_EN
    if (test_mode)
      w_rgb = bar_color(w_x);
`endif
    if (!w_act)
      w_rgb = COLOR_BLACK;
  end

  logic    r_hsync;
  logic    r_vsync;
  logic    r_active;
  rgb444_t r_rgb;
  logic    r_frame_start;

  // Stage 2: colour and sync registered together so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync  <= ~SYNC_POL;
      r_vsync  <= ~SYNC_POL;
      r_active <= 1'b0;
      r_rgb    <= COLOR_BLACK;
    end else if (w_tick) begin
      r_hsync  <= w_hs_on ? SYNC_POL : ~SYNC_POL;
      r_vsync  <= w_vs_on ? SYNC_POL : ~SYNC_POL;
      r_active <= w_act;
      r_rgb    <= w_rgb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_frame_start <= 1'b0;
    else
      r_frame_start <= w_y_wrap;
  end

  assign x           = w_x;
  assign y           = w_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign active      = r_active;
  assign red         = r_rgb[11:8];
  assign green       = r_rgb[7:4];
  assign blue        = r_rgb[3:0];
  assign frame_start = r_frame_start;

endmodule
